// File: rtl/ahb2apb_bridge_v2.sv
// AHB-Lite to APB4 bridge: one outstanding transfer, slot decode from HADDR,
// byte strobes from HSIZE/HADDR, two-cycle AHB error response and ACCESS timeout.
module ahb2apb_bridge_v2 #(
    parameter int unsigned NUM_SLOTS   = 16,
    parameter int unsigned SLOT_LSB    = 24,
    parameter int unsigned PADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                   HCLK,
    input  logic                   HRESETN,
    input  logic                   HSEL,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [31:0]            HWDATA,
    input  logic                   HREADYIN,
    output logic                   HREADYOUT,
    output logic [31:0]            HRDATA,
    output logic                   HRESP,
    output logic [NUM_SLOTS-1:0]   PSEL,
    output logic [PADDR_WIDTH-1:0] PADDR,
    output logic                   PWRITE,
    output logic                   PENABLE,
    output logic [31:0]            PWDATA,
    output logic [3:0]             PSTRB,
    input  logic [31:0]            PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR,
    output logic                   TOUT
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   accept;
    logic                   slot_bad;
    logic                   timeout_hit;
    logic [3:0]             h_slot;
    logic [3:0]             slot_q;
    logic [3:0]             sel_slot;
    logic [3:0]             wr_strb;
    logic [NUM_SLOTS-1:0]   psel_onehot;
    logic [CNT_W-1:0]       cnt;
    logic                   unused_ok;

    // HTRANS[0] only distinguishes NONSEQ from SEQ, which the bridge treats alike
    assign unused_ok = HTRANS[0];

    // Next-state decode, transfer acceptance, slot and strobe decode
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        h_slot      = HADDR[SLOT_LSB +: 4];
        slot_bad    = (32'(h_slot) >= NUM_SLOTS);
        sel_slot    = (state == ST_LATCH) ? slot_q : h_slot;
        psel_onehot = NUM_SLOTS'(1) << sel_slot;

        case (HSIZE)
            3'd0:    wr_strb = 4'b0001 << HADDR[1:0];
            3'd1:    wr_strb = HADDR[1] ? 4'b1100 : 4'b0011;
            default: wr_strb = 4'b1111;
        endcase

        case (state)
            ST_IDLE, ST_ERR2: begin
                accept = HSEL && HREADYIN && HTRANS[1];
                if (!accept)       state_next = ST_IDLE;
                else if (slot_bad) state_next = ST_ERR1;
                else if (HWRITE)   state_next = ST_LATCH;
                else               state_next = ST_SETUP;
            end
            ST_LATCH:  state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    state_next = PSLVERR ? ST_ERR1 : ST_IDLE;
                end else if ((TIMEOUT != 0) && ((32'(cnt) + 32'd1) == TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_ERR1;
                end
            end
            ST_ERR1:   state_next = ST_ERR2;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (!HRESETN) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Registered bus outputs, latched transfer attributes and wait counter
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            TOUT      <= 1'b0;
            slot_q    <= '0;
            cnt       <= '0;
        end else begin
            HREADYOUT <= (state_next == ST_IDLE) || (state_next == ST_ERR2);
            HRESP     <= (state_next == ST_ERR1) || (state_next == ST_ERR2);
            PENABLE   <= (state_next == ST_ACCESS);
            TOUT      <= timeout_hit;

            if (state_next == ST_SETUP)       PSEL <= psel_onehot;
            else if (state_next != ST_ACCESS) PSEL <= '0;

            if (accept && !slot_bad) begin
                PADDR  <= HADDR[PADDR_WIDTH-1:0];
                PWRITE <= HWRITE;
                PSTRB  <= HWRITE ? wr_strb : 4'b0000;
                slot_q <= h_slot;
            end

            if (state == ST_LATCH) PWDATA <= HWDATA;

            if ((state == ST_ACCESS) && PREADY && !PSLVERR && !PWRITE) HRDATA <= PRDATA;

            if (state_next == ST_SETUP)            cnt <= '0;
            else if ((state == ST_ACCESS) && !PREADY) cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge_v2.sv
// Scoreboard bench for ahb2apb_bridge_v2: driver pushes expected responses,
// monitor pops and compares when each AHB transfer completes.
module tb_ahb2apb_bridge_v2;

    localparam int NS = 4;
    localparam int TO = 4;

    logic          HCLK, HRESETN, HSEL, HWRITE, HREADYIN, HREADYOUT, HRESP;
    logic          PWRITE, PENABLE, PREADY, PSLVERR, TOUT;
    logic [31:0]   HADDR, HWDATA, HRDATA, PADDR, PWDATA, PRDATA;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [3:0]    PSTRB;
    logic [NS-1:0] PSEL;

    ahb2apb_bridge_v2 #(
        .NUM_SLOTS(NS), .SLOT_LSB(24), .PADDR_WIDTH(32), .TIMEOUT(TO)
    ) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .PSEL(PSEL),
        .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .TOUT(TOUT)
    );

    typedef struct {
        int            waits;
        int            hresp_n;
        int            tout_n;
        logic [NS-1:0] psel;
        logic [31:0]   paddr;
        logic          pwrite;
        logic [3:0]    pstrb;
        logic [31:0]   pwdata;
        logic [31:0]   hrdata;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          plan_wait = 0;
    logic        plan_err  = 1'b0;
    logic [31:0] exp_hrdata = 32'h0;
    logic [31:0] smem[logic [29:0]];
    logic [31:0] mmem[logic [29:0]];

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] fill(input logic [29:0] k);
        return {2'b00, k} ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // APB slave: memory with per-transfer wait/error plan
    initial begin
        int          acc_n;
        logic        rdy;
        logic [29:0] k;
        logic [31:0] w;
        acc_n = 0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
        forever begin
            @(negedge HCLK);
            if (PSEL != 0 && PENABLE) begin
                rdy     = (acc_n >= plan_wait);
                k       = PADDR[31:2];
                w       = smem.exists(k) ? smem[k] : fill(k);
                PREADY  = rdy;
                PSLVERR = rdy && plan_err;
                PRDATA  = rdy ? w : $urandom;
                if (rdy && PWRITE && !plan_err) begin
                    for (int b = 0; b < 4; b++)
                        if (PSTRB[b]) w[8*b +: 8] = PWDATA[8*b +: 8];
                    smem[k] = w;
                end
                acc_n++;
            end else begin
                acc_n   = 0;
                PREADY  = 1'($urandom);
                PSLVERR = 1'($urandom);
                PRDATA  = $urandom;
            end
        end
    end

    // Monitor: accumulate observations over a wait run, compare at completion
    initial begin
        int            low_n, hr_n, to_n, err_psel;
        logic [NS-1:0] ps;
        logic [31:0]   pa, pw;
        logic          pwr;
        logic [3:0]    pst;
        exp_t          e;
        low_n = 0; hr_n = 0; to_n = 0; err_psel = 0;
        ps = '0; pa = '0; pw = '0; pwr = 1'b0; pst = '0;
        forever begin
            @(negedge HCLK);
            if (!HRESETN) begin
                low_n = 0; hr_n = 0; to_n = 0; err_psel = 0; ps = '0;
            end else begin
                if (HRESP) hr_n++;
                if (TOUT) to_n++;
                if (HRESP && PSEL != 0) err_psel++;
                if (!HREADYOUT) begin
                    low_n++;
                    if (PSEL != 0 && !PENABLE) begin
                        ps = PSEL; pa = PADDR; pwr = PWRITE; pst = PSTRB;
                    end
                    if (PENABLE) pw = PWDATA;
                end else if (low_n > 0) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_xfer_waits", 32'(low_n), 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("wait_cycles", 32'(low_n), 32'(e.waits));
                        chk("hresp_cycles", 32'(hr_n), 32'(e.hresp_n));
                        chk("tout_pulses", 32'(to_n), 32'(e.tout_n));
                        chk("psel", 32'(ps), 32'(e.psel));
                        if (e.psel != 0) begin
                            chk("paddr", pa, e.paddr);
                            chk("pwrite", 32'(pwr), 32'(e.pwrite));
                            chk("pstrb", 32'(pst), 32'(e.pstrb));
                            if (e.pwrite) chk("pwdata", pw, e.pwdata);
                        end
                        chk("hrdata", HRDATA, e.hrdata);
                        chk("psel_during_err", 32'(err_psel), 32'd0);
                        chk("apb_idle_at_done", 32'({PENABLE, PSEL}), 32'd0);
                    end
                    low_n = 0; hr_n = 0; to_n = 0; err_psel = 0; ps = '0;
                    done_cnt++;
                end
            end
        end
    end

    task automatic drive_phases(input logic [31:0] addr, input logic wr,
                                input logic [2:0] size, input logic [31:0] wd);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = $urandom; HWDATA = wd;
    endtask

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wd, input int nwait, input logic err);
        exp_t        e;
        int          slot, start;
        logic        bad, to, fail;
        logic [3:0]  st;
        logic [29:0] k;
        logic [31:0] w;
        slot = int'(addr[27:24]);
        bad  = (slot >= NS);
        to   = !bad && (nwait >= TO);
        fail = bad || to || err;
        if (!wr)            st = 4'd0;
        else if (size == 0) st = 4'(1 << (addr % 4));
        else if (size == 1) st = ((addr % 4) >= 2) ? 4'd12 : 4'd3;
        else                st = 4'd15;
        e.psel    = bad ? '0 : NS'(1 << slot);
        e.waits   = bad ? 1 : to ? ((wr ? 1 : 0) + 1 + TO + 1) : ((wr ? 3 : 2) + nwait + (err ? 1 : 0));
        e.hresp_n = fail ? 2 : 0;
        e.tout_n  = to ? 1 : 0;
        e.paddr   = addr;
        e.pwrite  = wr;
        e.pstrb   = st;
        e.pwdata  = wd;
        k = addr[31:2];
        w = mmem.exists(k) ? mmem[k] : fill(k);
        if (!fail && wr) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
            mmem[k] = w;
        end
        if (!fail && !wr) exp_hrdata = w;
        e.hrdata  = exp_hrdata;
        plan_wait = nwait;
        plan_err  = err;
        sbq.push_back(e);
        start = done_cnt;
        drive_phases(addr, wr, size, wd);
        for (int i = 0; i < 100 && done_cnt == start; i++) @(negedge HCLK);
        if (done_cnt == start) begin
            chk("xfer_completion", 32'(done_cnt), 32'(start + 1));
            void'(sbq.pop_back());
        end
    endtask

    task automatic noop_cycle(input int kind);
        @(posedge HCLK); #1;
        case (kind)
            0:       begin HSEL = 1'b1; HTRANS = 2'b01; end
            1:       begin HSEL = 1'b0; HTRANS = 2'b10; end
            default: begin HSEL = 1'b1; HTRANS = 2'b10; HREADYIN = 1'b0; end
        endcase
        HADDR = 32'h0100_0000; HWRITE = 1'b1;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HREADYIN = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
        chk({tag, "_hresp"}, 32'(HRESP), 32'd0);
        chk({tag, "_psel_penable"}, 32'({PENABLE, PSEL}), 32'd0);
        chk({tag, "_hrdata"}, HRDATA, 32'd0);
        chk({tag, "_paddr"}, PADDR, 32'd0);
        chk({tag, "_pwdata"}, PWDATA, 32'd0);
        chk({tag, "_tout_pwrite_pstrb"}, 32'({TOUT, PWRITE, PSTRB}), 32'd0);
    endtask

    task automatic reset_mid_access();
        plan_wait = 3;
        plan_err  = 1'b0;
        drive_phases(32'h0000_0008, 1'b0, 3'd2, 32'h0);
        for (int i = 0; i < 20 && !PENABLE; i++) @(negedge HCLK);
        chk("reached_access", 32'(PENABLE), 32'd1);
        @(posedge HCLK); #1;
        HRESETN = 1'b0;
        @(negedge HCLK);
        @(negedge HCLK);
        check_reset_outputs("rst_mid");
        #1 HRESETN = 1'b1;
        exp_hrdata = 32'h0;
    endtask

    initial begin
        logic [31:0] addr;
        logic [29:0] k;
        int          r, nw;
        HRESETN = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
        HSIZE = 3'd0; HWDATA = '0; HREADYIN = 1'b1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check_reset_outputs("rst_init");
        #1 HRESETN = 1'b1;

        k = 30'(32'h0300_0010 >> 2);
        smem[k] = 32'hDEAD_BEEF;
        mmem[k] = 32'hDEAD_BEEF;
        xfer(32'h0300_0010, 1'b0, 3'd2, 32'h0, 0, 1'b0);          // zero-wait read, slot 3
        xfer(32'h0100_0003, 1'b1, 3'd0, 32'hAA00_0000, 0, 1'b0);  // byte write, top lane
        xfer(32'h0300_0010, 1'b0, 3'd2, 32'h0, 3, 1'b1);          // slave error after waits
        xfer(32'h0100_0000, 1'b0, 3'd2, 32'h0, 50, 1'b0);         // read timeout
        xfer(32'h0200_0004, 1'b1, 3'd2, 32'h1234_5678, 50, 1'b0); // write timeout
        xfer(32'h0500_0000, 1'b0, 3'd2, 32'h0, 0, 1'b0);          // slot beyond NUM_SLOTS
        xfer(32'h0200_0006, 1'b1, 3'd1, 32'hBEEF_0000, 1, 1'b0);  // upper halfword write
        xfer(32'h0200_0004, 1'b0, 3'd2, 32'h0, 0, 1'b0);          // read it back
        xfer(32'h0100_0000, 1'b0, 3'd2, 32'h0, 3, 1'b0);          // just under timeout
        reset_mid_access();

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) noop_cycle($urandom_range(0, 2));
            addr = (32'($urandom_range(0, 5)) << 24) | (32'($urandom_range(0, 3)) << 2)
                 | 32'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            nw = (r < 5) ? 0 : (r == 5) ? 1 : (r == 6) ? 2 : (r == 7) ? 3 : (r == 8) ? TO : 2;
            xfer(addr, 1'($urandom), 3'($urandom_range(0, 3)), $urandom, nw,
                 ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge HCLK);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge_v2.md
AHB2APB_BRIDGE_V2 -- requirements
Module: ahb2apb_bridge_v2
Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 16, number of APB slots (1..16).
REQ-002 SHALL have parameter SLOT_LSB, default 24, slot index = HADDR[SLOT_LSB+3:SLOT_LSB].
REQ-003 SHALL have parameter PADDR_WIDTH, default 32, PADDR width (≤32).
REQ-004 SHALL have parameter TIMEOUT, default 255, max PREADY-low ACCESS cycles; 0 disables.
REQ-005 HCLK  in  1  sole clock, rising edge.
REQ-006 HRESETN  in  1  reset, synchronous, active-low.
REQ-007 HSEL  in  1  bridge select.
REQ-008 HADDR  in  32  AHB address.
REQ-009 HTRANS  in  2  AHB transfer type; bit1=1 means NONSEQ/SEQ.
REQ-010 HWRITE  in  1  write when 1.
REQ-011 HSIZE  in  3  transfer size.
REQ-012 HWDATA  in  32  write data, valid in data phase.
REQ-013 HREADYIN  in  1  bus-level ready.
REQ-014 HREADYOUT  out  1  bridge ready.
REQ-015 HRDATA  out  32  registered read data.
REQ-016 HRESP  out  1  1=ERROR.
REQ-017 PSEL  out  NUM_SLOTS  one-hot slot select.
REQ-018 PADDR  out  PADDR_WIDTH  APB address.
REQ-019 PWRITE  out  1  APB direction.
REQ-020 PENABLE  out  1  APB access phase.
REQ-021 PWDATA  out  32  APB write data.
REQ-022 PSTRB  out  4  APB4 byte strobes.
REQ-023 PRDATA  in  32  APB read data.
REQ-024 PREADY  in  1  APB slave ready.
REQ-025 PSLVERR  in  1  APB slave error.
REQ-026 TOUT  out  1  one-cycle timeout pulse.
Function
REQ-027 Valid transfer = HSEL & HREADYIN & HTRANS[1], sampled only when HREADYOUT=1 (IDLE or ERR2); latches HADDR, HWRITE, HSIZE, slot index.
REQ-028 States IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2; HREADYOUT=1 only in IDLE and ERR2.
REQ-029 Valid transfer: slot ≥ NUM_SLOTS -> ERR1; write -> LATCH; read -> SETUP.
REQ-030 LATCH: captures HWDATA into PWDATA; -> SETUP.
REQ-031 SETUP: PSEL[slot]=1, PENABLE=0, PADDR=latched HADDR[PADDR_WIDTH-1:0]; -> ACCESS.
REQ-032 ACCESS: PSEL[slot]=1, PENABLE=1; PREADY=1 & PSLVERR=0 -> IDLE, read loads HRDATA<=PRDATA; PREADY=1 & PSLVERR=1 -> ERR1.
REQ-033 Zero-wait latency: read 2 wait cycles (HREADYOUT low), write 3; each PREADY-low cycle adds 1.
REQ-034 Timeout counter clears on SETUP entry, increments per ACCESS cycle with PREADY=0; reaching TIMEOUT (≠0) -> ERR1, TOUT=1 for that cycle, PSEL/PENABLE drop next cycle.
REQ-035 ERR1: HRESP=1, HREADYOUT=0; ERR2: HRESP=1, HREADYOUT=1; ERR2 -> LATCH/SETUP/ERR1 on valid transfer, else IDLE.
REQ-036 PSTRB for writes: HSIZE=0 -> 1<<HADDR[1:0]; HSIZE=1 -> 0011 or 1100 by HADDR[1]; HSIZE≥2 -> 1111; reads 0000; held through SETUP/ACCESS.
REQ-037 PSEL/PENABLE zero outside SETUP/ACCESS; PADDR, PWRITE, PWDATA, PSTRB, HRDATA hold last values when idle; HRDATA unchanged on error/timeout.
Reset
REQ-038 HRESETN=0 at edge: state IDLE, counter 0, HREADYOUT=1, all other outputs 0; in-flight transfer abandoned, no HRESP or HRDATA update.
REQ-039 Reset mid-ACCESS SHALL drop PSEL/PENABLE on the same edge.
Verification
REQ-040 Read 0x0300_0010, PREADY=1, PRDATA=0xDEADBEEF -> PSEL=0x0008, 2 HREADYOUT-low cycles, HRDATA=0xDEADBEEF.
REQ-041 Byte write 0x0100_0003, HWDATA=0xAA000000 -> PSTRB=1000, PWDATA=0xAA000000, 3 wait cycles.
REQ-042 Read, PREADY low 3 cycles then PSLVERR=1 -> 5 wait cycles then 2-cycle HRESP=1, HRDATA unchanged.
REQ-043 TIMEOUT=4, PREADY stuck 0 -> TOUT pulse after 4 ACCESS cycles, ERR1/ERR2, PSEL=0.
REQ-044 NUM_SLOTS=4, access slot 5 -> no PSEL, immediate 2-cycle ERROR.
REQ-045 HRESETN=0 during ACCESS -> next edge all outputs reset values, HREADYOUT=1.
